// File: rtl/cache_arbiter.sv
// cache_arbiter: two-client (L1I read-only, L1D read/write) arbiter in front of
// the L2 request port. One transaction is granted at a time. The grant is held
// until l2_resp arrives, and the response goes back only to the granted client.
// Round-robin tie-breaking: when both clients request, the one served last loses.
module cache_arbiter #(
  parameter int s_line = 256,
  parameter int s_mask = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       i_address,
  input  logic              i_read,
  output logic [s_line-1:0] i_rdata,
  output logic              i_resp,
  input  logic [31:0]       d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [s_line-1:0] d_wdata,
  output logic [s_line-1:0] d_rdata,
  output logic              d_resp,
  output logic [31:0]       l2_address,
  output logic              l2_read,
  output logic              l2_write,
  output logic [s_line-1:0] l2_wdata,
  output logic [s_mask-1:0] l2_byte_enable,
  input  logic [s_line-1:0] l2_rdata,
  input  logic              l2_resp
);

  typedef enum logic [1:0] {IDLE = 2'd0, SERVE_I = 2'd1, SERVE_D = 2'd2} state_t;
  typedef enum logic {GRANT_I = 1'b0, GRANT_D = 1'b1} grant_t;

  state_t state, state_nxt;
  grant_t last_grant, last_grant_nxt;

  logic d_req;
  assign d_req = d_read | d_write;

  // State and round-robin history registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Next-state: arbitrate only from IDLE, so every transaction is separated
  // from the next by at least one cycle with the L2 request low.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (d_req && i_read)
          state_nxt = (last_grant == GRANT_I) ? SERVE_D : SERVE_I;
        else if (d_req)
          state_nxt = SERVE_D;
        else if (i_read)
          state_nxt = SERVE_I;
      end
      SERVE_I: begin
        if (l2_resp) begin
          state_nxt      = IDLE;
          last_grant_nxt = GRANT_I;
        end
      end
      SERVE_D: begin
        if (l2_resp) begin
          state_nxt      = IDLE;
          last_grant_nxt = GRANT_D;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output mux: everything is forced low while rst is high, so a pending
  // response in the reset cycle is discarded and nothing leaks out.
  always_comb begin
    l2_address     = '0;
    l2_read        = 1'b0;
    l2_write       = 1'b0;
    l2_wdata       = '0;
    l2_byte_enable = '0;
    i_rdata        = '0;
    i_resp         = 1'b0;
    d_rdata        = '0;
    d_resp         = 1'b0;
    if (!rst) begin
      case (state)
        SERVE_I: begin
          l2_address = i_address;
          l2_read    = 1'b1;
          if (l2_resp) begin
            i_resp  = 1'b1;
            i_rdata = l2_rdata;
          end
        end
        SERVE_D: begin
          l2_address     = d_address;
          // read+write together is treated as a write
          l2_read        = d_read & ~d_write;
          l2_write       = d_write;
          l2_wdata       = d_wdata;
          l2_byte_enable = '1;
          if (l2_resp) begin
            d_resp  = 1'b1;
            d_rdata = l2_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // A D-cache request must never be both read and write.
  a_d_rw_excl: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter. Inputs are driven 1ns after the rising edge
// and outputs are checked 1ns after the inputs settle.
module tb_cache_arbiter;
  localparam int s_line = 256;
  localparam int s_mask = 32;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] i_address, d_address, l2_address;
  logic i_read, i_resp, d_read, d_write, d_resp, l2_read, l2_write, l2_resp;
  logic [s_line-1:0] i_rdata, d_wdata, d_rdata, l2_wdata, l2_rdata;
  logic [s_mask-1:0] l2_byte_enable;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [s_line-1:0] AA   = {32{8'hAA}};
  localparam logic [s_line-1:0] D55  = {32{8'h55}};
  localparam logic [s_line-1:0] WDAT = {8{32'h1234_5678}};
  localparam logic [s_line-1:0] C3   = {32{8'hC3}};

  cache_arbiter #(.s_line(s_line), .s_mask(s_mask)) dut (
    .clk(clk), .rst(rst),
    .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_address(l2_address), .l2_read(l2_read), .l2_write(l2_write),
    .l2_wdata(l2_wdata), .l2_byte_enable(l2_byte_enable),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; i_read = 0; d_read = 0; d_write = 0; l2_resp = 0; l2_rdata = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    i_address = '0; d_address = '0; d_wdata = '0;
    rst = 1'b1; i_read = 0; d_read = 0; d_write = 0; l2_resp = 0; l2_rdata = '0;
    step(); step();
    n_vec++; if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0) begin n_err++; $display("FAIL reset_ctl got %b exp 0000", {l2_read, l2_write, i_resp, d_resp}); end
    n_vec++; if ((l2_address | l2_byte_enable) !== 32'h0 || (l2_wdata | i_rdata | d_rdata) !== '0) begin n_err++; $display("FAIL reset_bus got addr %h be %h", l2_address, l2_byte_enable); end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_vec++; if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0 || l2_address !== 32'h0 || l2_byte_enable !== '0) begin n_err++; $display("FAIL idle_quiet cyc %0d got ctl %b addr %h", k, {l2_read, l2_write, i_resp, d_resp}, l2_address); end
    end
  endtask

  task automatic test_iread;
    i_read = 1'b1; i_address = 32'h0000_1000; #1;
    n_vec++; if (l2_read !== 1'b0) begin n_err++; $display("FAIL iread_no_passthru got %b exp 0", l2_read); end
    step();
    n_vec++; if (l2_read !== 1'b1 || l2_address !== 32'h0000_1000) begin n_err++; $display("FAIL iread_req got rd %b addr %h exp 1 00001000", l2_read, l2_address); end
    n_vec++; if (l2_write !== 1'b0 || l2_byte_enable !== '0 || l2_wdata !== '0) begin n_err++; $display("FAIL iread_wr_fields got wr %b be %h", l2_write, l2_byte_enable); end
    step(); step(); step();
    n_vec++; if (i_resp !== 1'b0 || l2_read !== 1'b1) begin n_err++; $display("FAIL iread_hold got resp %b rd %b exp 0 1", i_resp, l2_read); end
    l2_resp = 1'b1; l2_rdata = AA; #1;
    n_vec++; if (i_resp !== 1'b1 || i_rdata !== AA) begin n_err++; $display("FAIL iread_resp got resp %b rdata %h exp 1 aa..", i_resp, i_rdata); end
    n_vec++; if (d_resp !== 1'b0 || d_rdata !== '0) begin n_err++; $display("FAIL iread_d_quiet got resp %b rdata %h exp 0", d_resp, d_rdata); end
    step();
    l2_resp = 1'b0; l2_rdata = '0; i_read = 1'b0; #1;
    n_vec++; if (i_resp !== 1'b0 || l2_read !== 1'b0 || i_rdata !== '0) begin n_err++; $display("FAIL iread_after got resp %b rd %b exp 0 0", i_resp, l2_read); end
  endtask

  task automatic test_dwrite;
    step();
    d_write = 1'b1; d_address = 32'h8000_0020; d_wdata = WDAT;
    step();
    n_vec++; if (l2_write !== 1'b1 || l2_read !== 1'b0 || l2_address !== 32'h8000_0020) begin n_err++; $display("FAIL dwr_req got wr %b rd %b addr %h exp 1 0 80000020", l2_write, l2_read, l2_address); end
    n_vec++; if (l2_byte_enable !== 32'hFFFF_FFFF || l2_wdata !== WDAT) begin n_err++; $display("FAIL dwr_data got be %h wdata %h", l2_byte_enable, l2_wdata); end
    step();
    n_vec++; if (l2_read !== 1'b0 || d_resp !== 1'b0 || l2_write !== 1'b1) begin n_err++; $display("FAIL dwr_hold got rd %b resp %b wr %b exp 0 0 1", l2_read, d_resp, l2_write); end
    step();
    l2_resp = 1'b1; l2_rdata = C3; #1;
    n_vec++; if (d_resp !== 1'b1 || i_resp !== 1'b0 || l2_read !== 1'b0 || d_rdata !== C3) begin n_err++; $display("FAIL dwr_resp got dresp %b iresp %b rd %b", d_resp, i_resp, l2_read); end
    step();
    l2_resp = 1'b0; l2_rdata = '0; d_write = 1'b0; #1;
    n_vec++; if (d_resp !== 1'b0 || l2_write !== 1'b0 || d_rdata !== '0) begin n_err++; $display("FAIL dwr_after got resp %b wr %b exp 0 0", d_resp, l2_write); end
  endtask

  task automatic test_tie;
    do_reset();
    i_read = 1'b1; d_read = 1'b1; i_address = 32'h0000_2000; d_address = 32'h0000_3000;
    step();
    n_vec++; if (l2_address !== 32'h0000_3000 || l2_read !== 1'b1) begin n_err++; $display("FAIL tie_first_d got addr %h rd %b exp 00003000 1", l2_address, l2_read); end
    l2_resp = 1'b1; l2_rdata = D55; #1;
    n_vec++; if (d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== D55 || i_rdata !== '0) begin n_err++; $display("FAIL tie_d_resp got d %b i %b", d_resp, i_resp); end
    step();
    l2_resp = 1'b0; d_read = 1'b0; #1;
    n_vec++; if (l2_read !== 1'b0) begin n_err++; $display("FAIL tie_gap got rd %b exp 0", l2_read); end
    step();
    n_vec++; if (l2_address !== 32'h0000_2000 || l2_read !== 1'b1) begin n_err++; $display("FAIL tie_then_i got addr %h rd %b exp 00002000 1", l2_address, l2_read); end
    l2_resp = 1'b1; #1;
    n_vec++; if (i_resp !== 1'b1 || d_resp !== 1'b0) begin n_err++; $display("FAIL tie_i_resp got i %b d %b exp 1 0", i_resp, d_resp); end
    step();
    l2_resp = 1'b0; i_read = 1'b0;
    d_read = 1'b1;  // D alone, so D becomes last served
    step(); step();
    l2_resp = 1'b1; #1;
    n_vec++; if (d_resp !== 1'b1) begin n_err++; $display("FAIL solo_d_resp got %b exp 1", d_resp); end
    step();
    l2_resp = 1'b0; d_read = 1'b0;
    step();
    i_read = 1'b1; d_read = 1'b1;
    step();
    n_vec++; if (l2_address !== 32'h0000_2000) begin n_err++; $display("FAIL tie_repeat_i got addr %h exp 00002000", l2_address); end
    l2_resp = 1'b1; #1;
    n_vec++; if (i_resp !== 1'b1 || d_resp !== 1'b0) begin n_err++; $display("FAIL tie_repeat_resp got i %b d %b exp 1 0", i_resp, d_resp); end
    step();
    l2_resp = 1'b0; i_read = 1'b0; d_read = 1'b0;
  endtask

  task automatic test_back_to_back;
    do_reset();
    i_address = 32'h0000_A000; d_address = 32'h0000_B000;
    i_read = 1'b1; d_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic exp_d;
      exp_d = (k % 2 == 0);
      step();
      n_vec++; if (l2_address !== (exp_d ? 32'h0000_B000 : 32'h0000_A000)) begin n_err++; $display("FAIL b2b_grant txn %0d got addr %h exp_d %b", k, l2_address, exp_d); end
      step();
      l2_resp = 1'b1; #1;
      n_vec++; if ({d_resp, i_resp} !== {exp_d, ~exp_d}) begin n_err++; $display("FAIL b2b_resp txn %0d got d/i %b%b exp %b%b", k, d_resp, i_resp, exp_d, ~exp_d); end
      step();
      l2_resp = 1'b0; #1;
      n_vec++; if (l2_read !== 1'b0) begin n_err++; $display("FAIL b2b_gap txn %0d got rd %b exp 0", k, l2_read); end
    end
    i_read = 1'b0; d_read = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_reset();
    d_read = 1'b1; d_address = 32'h0000_4000;
    step();
    step();
    n_vec++; if (l2_read !== 1'b1 || l2_address !== 32'h0000_4000) begin n_err++; $display("FAIL rmid_pre got rd %b addr %h", l2_read, l2_address); end
    rst = 1'b1; l2_resp = 1'b1; l2_rdata = AA; #1;
    n_vec++; if (d_resp !== 1'b0 || l2_read !== 1'b0 || l2_address !== 32'h0 || d_rdata !== '0) begin n_err++; $display("FAIL rmid_in_rst got resp %b rd %b addr %h", d_resp, l2_read, l2_address); end
    step();
    rst = 1'b0; d_read = 1'b0; #1;
    n_vec++; if (d_resp !== 1'b0 || d_rdata !== '0 || l2_read !== 1'b0 || i_resp !== 1'b0) begin n_err++; $display("FAIL rmid_idle_resp got dresp %b iresp %b rd %b", d_resp, i_resp, l2_read); end
    l2_resp = 1'b0; i_read = 1'b1; i_address = 32'h0000_5000;
    step();
    n_vec++; if (l2_read !== 1'b1 || l2_address !== 32'h0000_5000) begin n_err++; $display("FAIL rmid_new_req got rd %b addr %h", l2_read, l2_address); end
    l2_resp = 1'b1; l2_rdata = D55; #1;
    n_vec++; if (i_resp !== 1'b1 || i_rdata !== D55 || d_resp !== 1'b0) begin n_err++; $display("FAIL rmid_new_resp got iresp %b dresp %b", i_resp, d_resp); end
    step();
    l2_resp = 1'b0; i_read = 1'b0;
  endtask

  initial begin
    test_reset();
    test_iread();
    test_dwrite();
    test_tie();
    test_back_to_back();
    test_reset_mid();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
